// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select and a request/ack handshake to instruction memory.
// Optional macro ALIGN_CHECK_EN adds misalign_err and a HALT state on misaligned redirects.
module fetch_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCWrite,
  input  logic [2:0]        pcSrc,
  input  logic [DATA_W-1:0] branch_target,
  input  logic [DATA_W-1:0] jump_jpc,
  input  logic [DATA_W-1:0] reg_target,
  input  logic [DATA_W-1:0] stack_target,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pc_plus4
`ifdef ALIGN_CHECK_EN
  ,
  output logic              misalign_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_VALID
`ifdef ALIGN_CHECK_EN
    ,
    S_HALT
`endif
  } state_t;

  localparam logic [DATA_W-1:0] JUMP_HI_MASK = {4'hF, {(DATA_W-4){1'b0}}};
  localparam logic [DATA_W-1:0] WORD_MASK    = {{(DATA_W-2){1'b1}}, 2'b00};

  state_t            state, state_nxt;
  logic [DATA_W-1:0] next_pc;
  logic [DATA_W-1:0] pc_load;
  logic              load_instr;
  logic              load_pc;
`ifdef ALIGN_CHECK_EN
  logic              set_err;
`endif

  assign pc_plus4  = pc + {{(DATA_W-3){1'b0}}, 3'd4};
  assign imem_addr = pc;

  always_comb begin
    next_pc = pc_plus4;
    case (pcSrc)
      3'b001:  next_pc = branch_target;
      3'b010:  next_pc = (pc_plus4 & JUMP_HI_MASK) | (jump_jpc & ~JUMP_HI_MASK);
      3'b011:  next_pc = reg_target;
      3'b100:  next_pc = stack_target;
      default: next_pc = pc_plus4;
    endcase
  end

`ifdef ALIGN_CHECK_EN
  // Misaligned targets are loaded as-is so the faulting address stays visible in pc.
  assign pc_load = next_pc;
`else
  assign pc_load = next_pc & WORD_MASK;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    load_instr = 1'b0;
    load_pc    = 1'b0;
`ifdef ALIGN_CHECK_EN
    set_err    = 1'b0;
`endif
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          load_instr = 1'b1;
          state_nxt  = S_VALID;
        end
      end
      S_VALID: begin
        if (PCWrite) begin
          load_pc   = 1'b1;
          state_nxt = S_FETCH;
`ifdef ALIGN_CHECK_EN
          if (next_pc[1:0] != 2'b00) begin
            set_err   = 1'b1;
            state_nxt = S_HALT;
          end
`endif
        end
      end
`ifdef ALIGN_CHECK_EN
      S_HALT: state_nxt = S_HALT;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
    end else begin
      if (load_instr) begin
        instruction <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (load_pc) begin
        pc          <= pc_load;
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         misalign_err <= 1'b0;
    else if (set_err) misalign_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, fetch handshake, stall, next-PC sources, wrap, mid-fetch reset, alignment.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        PCWrite;
  logic [2:0]  pcSrc;
  logic [31:0] branch_target, jump_jpc, reg_target, stack_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .PCWrite       (PCWrite),
    .pcSrc         (pcSrc),
    .branch_target (branch_target),
    .jump_jpc      (jump_jpc),
    .reg_target    (reg_target),
    .stack_target  (stack_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4)
`ifdef ALIGN_CHECK_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // From FETCH: ack with data in one cycle, land in VALID.
  task automatic fetch_ack(input logic [31:0] data);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    chk("fa_valid", {31'd0, instr_valid}, 32'd1);
    chk("fa_instr", instruction, data);
  endtask

  // From VALID: one PCWrite edge with the given source, land in FETCH.
  task automatic redirect(input logic [2:0] src);
    PCWrite = 1'b1;
    pcSrc   = src;
    tick();
    PCWrite = 1'b0;
    pcSrc   = 3'b000;
  endtask

  initial begin
    rst = 1'b0; PCWrite = 1'b0; pcSrc = 3'b000;
    branch_target = '0; jump_jpc = '0; reg_target = '0; stack_target = '0;
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;

    // reset held with a stray ack present
    tick(); tick();
    chk("rst_pc",    pc, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_pc4",   pc_plus4, 32'h4);
`ifdef ALIGN_CHECK_EN
    chk("rst_err",   {31'd0, misalign_err}, 32'd0);
`endif

    // release: IDLE cycle discards the ack, then FETCH at address 0
    rst = 1'b1;
    tick();
    chk("idle_valid", {31'd0, instr_valid}, 32'd0);
    chk("idle_instr", instruction, 32'h0);
    chk("f0_req",     {31'd0, imem_req}, 32'd1);
    chk("f0_addr",    imem_addr, 32'h0);

    imem_rdata = 32'h8C220004;
    tick();
    chk("v0_instr", instruction, 32'h8C220004);
    chk("v0_valid", {31'd0, instr_valid}, 32'd1);
    chk("v0_req",   {31'd0, imem_req}, 32'd0);

    // stall 5 cycles; acks while not requesting are ignored
    imem_rdata = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_pc",    pc, 32'h0);
      chk("stall_instr", instruction, 32'h8C220004);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    imem_ack = 1'b0;

    redirect(3'b000);
    chk("seq_pc",    pc, 32'h4);
    chk("seq_valid", {31'd0, instr_valid}, 32'd0);
    chk("seq_req",   {31'd0, imem_req}, 32'd1);
    chk("seq_addr",  imem_addr, 32'h4);

    // PCWrite ignored while fetching
    branch_target = 32'h00000100;
    PCWrite = 1'b1; pcSrc = 3'b001;
    tick();
    PCWrite = 1'b0; pcSrc = 3'b000;
    chk("fetch_hold_pc",  pc, 32'h4);
    chk("fetch_hold_req", {31'd0, imem_req}, 32'd1);

    fetch_ack(32'hA0000001);
    branch_target = 32'h40000010;
    redirect(3'b001);
    chk("branch_pc", pc, 32'h40000010);

    fetch_ack(32'hA0000002);
    jump_jpc = 32'h00000100;
    redirect(3'b010);
    chk("jump_pc", pc, 32'h40000100);

    fetch_ack(32'hA0000003);
    stack_target = 32'h00000ABC;
    redirect(3'b100);
    chk("stack_pc", pc, 32'h00000ABC);

    fetch_ack(32'hA0000004);
    reg_target = 32'hFFFFFFFC;
    redirect(3'b011);
    chk("reg_pc",   pc, 32'hFFFFFFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);

    fetch_ack(32'hA0000005);
    redirect(3'b000);
    chk("wrap_pc", pc, 32'h0);

    fetch_ack(32'hA0000006);
    redirect(3'b111);
    chk("src7_pc", pc, 32'h4);

    fetch_ack(32'hA0000007);
    redirect(3'b101);
    chk("src5_pc", pc, 32'h8);

    // mid-fetch reset while the ack is late
    tick();
    chk("late_req", {31'd0, imem_req}, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_pc",    pc, 32'h0);
    chk("arst_instr", instruction, 32'h0);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_req",   {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hBADBAD00;
    tick();
    chk("rst_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_ack_instr", instruction, 32'h0);
    rst = 1'b1;
    tick();
    chk("re_valid", {31'd0, instr_valid}, 32'd0);
    chk("re_instr", instruction, 32'h0);
    chk("re_req",   {31'd0, imem_req}, 32'd1);
    chk("re_addr",  imem_addr, 32'h0);
    imem_ack = 1'b0;
    fetch_ack(32'h12345678);

    // misaligned register target
    reg_target = 32'h00000006;
    redirect(3'b011);
`ifdef ALIGN_CHECK_EN
    chk("mis_err",   {31'd0, misalign_err}, 32'd1);
    chk("mis_pc",    pc, 32'h6);
    chk("mis_req",   {31'd0, imem_req}, 32'd0);
    chk("mis_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1; PCWrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_req",   {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_err",   {31'd0, misalign_err}, 32'd1);
    end
    imem_ack = 1'b0; PCWrite = 1'b0;
`else
    chk("mis_pc",  pc, 32'h4);
    chk("mis_req", {31'd0, imem_req}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
